// File: rtl/fifo_gen2_pkg.sv
// Shared sizing helpers and output-path encodings for the gen2 LPM FIFO.
package fifo_gen2_pkg;

    // Number of words addressed by a WIDTHU-bit pointer.
    function automatic int fifo_depth(input int widthu);
        return 1 << widthu;
    endfunction

    // Word count spans 0..DEPTH inclusive, so it needs one bit more than a pointer.
    function automatic int count_width(input int widthu);
        return widthu + 1;
    endfunction

    // Default almost-empty threshold: two words of slack on deep FIFOs, none on tiny ones.
    function automatic int default_ae_level(input int widthu);
        return (fifo_depth(widthu) >= 8) ? 2 : 0;
    endfunction

    // Default almost-full threshold mirrors the almost-empty slack from the top.
    function automatic int default_af_level(input int widthu);
        return fifo_depth(widthu) - default_ae_level(widthu);
    endfunction

    // Side-band ports keep at least one bit so a zero-width lane still elaborates.
    function automatic int side_port_width(input int par_width);
        return (par_width > 0) ? par_width : 1;
    endfunction

    // Where the output register takes its next value from.
    typedef enum logic [1:0] {
        Q_SRC_HOLD   = 2'd0,
        Q_SRC_RAM    = 2'd1,
        Q_SRC_BYPASS = 2'd2
    } q_src_e;

    // Which register currently drives {EDO,Q}.
    typedef enum logic {
        Q_SEL_RAM    = 1'b0,
        Q_SEL_BYPASS = 1'b1
    } q_sel_e;

endpackage

// File: rtl/fifo_gen2_dpram.sv
// Simple dual-port RAM: synchronous write, registered read with read-enable.
// Read-during-write to the same address returns the old contents.
module fifo_gen2_dpram
    import fifo_gen2_pkg::*;
#(
    parameter int DW = 5,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int DEPTH = fifo_depth(AW);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;
    logic [DW-1:0] rdata_d;

    // Write port: storage is never cleared, only overwritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Next read-register value: new word when enabled, otherwise hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Read output register, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/lpm_fifo_gen2.sv
// Single-clock FIFO with optional side-band lane, normal or showahead read,
// registered threshold flags and sticky overflow/underflow errors.
module lpm_fifo_gen2
    import fifo_gen2_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PAR_WIDTH = 1,
    parameter int WIDTHU    = 8,
    parameter int SHOWAHEAD = 0,
    parameter int AE_LEVEL  = default_ae_level(WIDTHU),
    parameter int AF_LEVEL  = default_af_level(WIDTHU)
) (
    input  logic                                  Clock,
    input  logic                                  Aclr,
    input  logic [WIDTH-1:0]                      Data,
    input  logic [side_port_width(PAR_WIDTH)-1:0] EDI,
    input  logic                                  WrReq,
    input  logic                                  RdReq,
    input  logic                                  ErrClr,
    output logic [WIDTH-1:0]                      Q,
    output logic [side_port_width(PAR_WIDTH)-1:0] EDO,
    output logic [count_width(WIDTHU)-1:0]        UsedW,
    output logic                                  Empty,
    output logic                                  Full,
    output logic                                  AlmostEmpty,
    output logic                                  AlmostFull,
    output logic                                  Overflow,
    output logic                                  Underflow
);

    localparam int DEPTH = fifo_depth(WIDTHU);
    localparam int CW    = count_width(WIDTHU);
    localparam int DW    = WIDTH + PAR_WIDTH;

    if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_level_check
        $error("lpm_fifo_gen2: thresholds must satisfy 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
    end

    logic              wr_ok;
    logic              rd_ok;
    logic [WIDTHU-1:0] wr_ptr_q, wr_ptr_d;
    logic [WIDTHU-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     used_q, used_d;
    logic              empty_q, empty_d;
    logic              full_q, full_d;
    logic              ae_q, ae_d;
    logic              af_q, af_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    logic [DW-1:0]     wr_word;
    logic [DW-1:0]     ram_rdata;
    logic [DW-1:0]     q_word;
    logic [DW-1:0]     byp_q, byp_d;
    q_sel_e            sel_q, sel_d;
    q_src_e            q_src;
    logic              ram_re;
    logic [WIDTHU-1:0] ram_raddr;

    // Side-band lane packing; with no lane the EDI/EDO storage disappears.
    if (PAR_WIDTH > 0) begin : g_side
        assign wr_word = {EDI, Data};
        assign EDO     = q_word[DW-1:WIDTH];
    end else begin : g_no_side
        logic unused_edi;
        assign unused_edi = ^EDI;
        assign wr_word    = Data;
        assign EDO        = '0;
    end

    // Accept rules, pointer/count update, flags and sticky errors.
    always_comb begin
        wr_ok    = WrReq & ~full_q;
        rd_ok    = RdReq & ~empty_q;
        wr_ptr_d = wr_ptr_q + WIDTHU'(wr_ok);
        rd_ptr_d = rd_ptr_q + WIDTHU'(rd_ok);
        used_d   = used_q + CW'(wr_ok) - CW'(rd_ok);
        empty_d  = (used_d == '0);
        full_d   = (used_d == CW'(DEPTH));
        ae_d     = (used_d <= CW'(AE_LEVEL));
        af_d     = (used_d >= CW'(AF_LEVEL));
        ovf_d    = (WrReq & full_q) | (ovf_q & ~ErrClr);
        udf_d    = (RdReq & empty_q) | (udf_q & ~ErrClr);
    end

    // Output-path source selection. In showahead mode the RAM is read one word
    // ahead (at the post-edge head); a word that becomes head on the same edge
    // it is written cannot come from the RAM yet, so it is captured directly.
    always_comb begin
        q_src     = Q_SRC_HOLD;
        ram_raddr = rd_ptr_q;
        if (SHOWAHEAD != 0) begin
            ram_raddr = rd_ptr_d;
            if (wr_ok && (empty_q || (used_q == CW'(1) && rd_ok))) begin
                q_src = Q_SRC_BYPASS;
            end else if (rd_ok && !empty_d) begin
                q_src = Q_SRC_RAM;
            end
        end else if (rd_ok) begin
            q_src = Q_SRC_RAM;
        end
        ram_re = (q_src == Q_SRC_RAM);
        byp_d  = byp_q;
        sel_d  = sel_q;
        if (q_src == Q_SRC_BYPASS) begin
            byp_d = wr_word;
            sel_d = Q_SEL_BYPASS;
        end else if (q_src == Q_SRC_RAM) begin
            sel_d = Q_SEL_RAM;
        end
    end

    // Control and status registers, all cleared by Aclr.
    always_ff @(posedge Clock or posedge Aclr) begin
        if (Aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            used_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            byp_q    <= '0;
            sel_q    <= Q_SEL_RAM;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            used_q   <= used_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            byp_q    <= byp_d;
            sel_q    <= sel_d;
        end
    end

    fifo_gen2_dpram #(
        .DW (DW),
        .AW (WIDTHU)
    ) u_ram (
        .clk   (Clock),
        .aclr  (Aclr),
        .we    (wr_ok),
        .waddr (wr_ptr_q),
        .wdata (wr_word),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign q_word      = (sel_q == Q_SEL_BYPASS) ? byp_q : ram_rdata;
    assign Q           = q_word[WIDTH-1:0];
    assign UsedW       = used_q;
    assign Empty       = empty_q;
    assign Full        = full_q;
    assign AlmostEmpty = ae_q;
    assign AlmostFull  = af_q;
    assign Overflow    = ovf_q;
    assign Underflow   = udf_q;

endmodule

// File: tb/tb_lpm_fifo_gen2.sv
// Scoreboard bench: one normal-read and one showahead instance share stimulus;
// a queue-based reference model predicts every output after each clock edge.
module tb_lpm_fifo_gen2;

    localparam int DEPTH = 256;
    localparam int AE    = 2;
    localparam int AF    = 254;

    logic       Clock, Aclr, WrReq, RdReq, ErrClr;
    logic [3:0] Data;
    logic [0:0] EDI;

    logic [3:0] q0, q1;
    logic [0:0] edo0, edo1;
    logic [8:0] used0, used1;
    logic       empty0, full0, ae0, af0, ovf0, udf0;
    logic       empty1, full1, ae1, af1, ovf1, udf1;

    typedef struct {
        int         used;
        bit         ovf;
        bit         udf;
        logic [4:0] q;
        logic [4:0] sa;
    } exp_t;

    exp_t       exp_q[$];
    logic [4:0] mdl[$];
    logic [4:0] m_last, m_head;
    bit         m_ovf, m_udf;
    int         n_pass  = 0;
    int         n_total = 0;

    lpm_fifo_gen2 #(.WIDTH(4), .PAR_WIDTH(1), .WIDTHU(8), .SHOWAHEAD(0),
                    .AE_LEVEL(AE), .AF_LEVEL(AF)) u_dut_n (
        .Clock(Clock), .Aclr(Aclr), .Data(Data), .EDI(EDI), .WrReq(WrReq),
        .RdReq(RdReq), .ErrClr(ErrClr), .Q(q0), .EDO(edo0), .UsedW(used0),
        .Empty(empty0), .Full(full0), .AlmostEmpty(ae0), .AlmostFull(af0),
        .Overflow(ovf0), .Underflow(udf0));

    lpm_fifo_gen2 #(.WIDTH(4), .PAR_WIDTH(1), .WIDTHU(8), .SHOWAHEAD(1),
                    .AE_LEVEL(AE), .AF_LEVEL(AF)) u_dut_sa (
        .Clock(Clock), .Aclr(Aclr), .Data(Data), .EDI(EDI), .WrReq(WrReq),
        .RdReq(RdReq), .ErrClr(ErrClr), .Q(q1), .EDO(edo1), .UsedW(used1),
        .Empty(empty1), .Full(full1), .AlmostEmpty(ae1), .AlmostFull(af1),
        .Overflow(ovf1), .Underflow(udf1));

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic void check(input string name, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    endfunction

    function automatic void model_reset();
        mdl.delete();
        m_last = '0;
        m_head = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_usedw_n"}, int'(used0), 0);
        check({tag, "_usedw_sa"}, int'(used1), 0);
        check({tag, "_empty"}, int'({empty0, empty1}), 3);
        check({tag, "_full"}, int'({full0, full1}), 0);
        check({tag, "_almost_empty"}, int'({ae0, ae1}), 3);
        check({tag, "_almost_full"}, int'({af0, af1}), 0);
        check({tag, "_errors"}, int'({ovf0, udf0, ovf1, udf1}), 0);
        check({tag, "_q_n"}, int'({edo0, q0}), 0);
        check({tag, "_q_sa"}, int'({edo1, q1}), 0);
    endtask

    // One clock of stimulus; the model advances and the expected post-edge state is queued.
    task automatic step(input bit wr, input bit rd, input logic [3:0] d,
                        input logic e, input bit clr);
        exp_t x;
        bit   wr_ok, rd_ok;
        @(negedge Clock);
        WrReq = wr; RdReq = rd; Data = d; EDI = e; ErrClr = clr;
        wr_ok = wr && (mdl.size() < DEPTH);
        rd_ok = rd && (mdl.size() != 0);
        if (wr && mdl.size() == DEPTH) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (rd && mdl.size() == 0) m_udf = 1'b1; else if (clr) m_udf = 1'b0;
        if (rd_ok) m_last = mdl.pop_front();
        if (wr_ok) mdl.push_back({e, d});
        if (mdl.size() != 0) m_head = mdl[0];
        x.used = mdl.size();
        x.ovf  = m_ovf;
        x.udf  = m_udf;
        x.q    = m_last;
        x.sa   = m_head;
        exp_q.push_back(x);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Monitor: after every rising edge, compare the DUTs with the oldest queued prediction.
    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge Clock);
            #1;
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("usedw_n", int'(used0), x.used);
                check("usedw_sa", int'(used1), x.used);
                check("empty_n", int'(empty0), int'(x.used == 0));
                check("empty_sa", int'(empty1), int'(x.used == 0));
                check("full_n", int'(full0), int'(x.used == DEPTH));
                check("full_sa", int'(full1), int'(x.used == DEPTH));
                check("almost_empty_n", int'(ae0), int'(x.used <= AE));
                check("almost_empty_sa", int'(ae1), int'(x.used <= AE));
                check("almost_full_n", int'(af0), int'(x.used >= AF));
                check("almost_full_sa", int'(af1), int'(x.used >= AF));
                check("overflow_n", int'(ovf0), int'(x.ovf));
                check("overflow_sa", int'(ovf1), int'(x.ovf));
                check("underflow_n", int'(udf0), int'(x.udf));
                check("underflow_sa", int'(udf1), int'(x.udf));
                check("q_normal", int'({edo0, q0}), int'(x.q));
                check("q_showahead", int'({edo1, q1}), int'(x.sa));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int nw;
        int iter;
        bit wr, rd;
        Aclr = 1'b1; WrReq = 1'b0; RdReq = 1'b0; ErrClr = 1'b0; Data = '0; EDI = '0;
        model_reset();
        #2;
        check_reset("por");
        @(negedge Clock);
        Aclr = 1'b0;

        // Three writes then three reads.
        step(1'b1, 1'b0, 4'h1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 4'h2, 1'b1, 1'b0);
        step(1'b1, 1'b0, 4'h3, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        idle();

        // Fill to full, overflow, dropped write alongside an accepted read, clear, drain.
        repeat (DEPTH) step(1'b1, 1'b0, 4'($urandom), 1'($urandom), 1'b0);
        step(1'b1, 1'b0, 4'hF, 1'b1, 1'b0);
        step(1'b1, 1'b1, 4'hE, 1'b1, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        while (mdl.size() != 0) step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);

        // Underflow with a concurrent accepted write, clear, then set-beats-clear.
        step(1'b1, 1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);

        // Write into empty, then simultaneous read+write at one word.
        step(1'b1, 1'b0, 4'h5, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'h6, 1'b1, 1'b0);

        // Shallow traffic across the pointer wrap, occupancy held in 1..4.
        nw = 0;
        iter = 0;
        while (nw < 300 && iter < 3000) begin
            wr = 1'($urandom);
            rd = 1'($urandom);
            if (mdl.size() >= 4) wr = 1'b0;
            if (mdl.size() <= 1 && !wr) rd = 1'b0;
            if (wr) nw++;
            step(wr, rd, 4'($urandom), 1'($urandom), 1'b0);
            iter++;
        end

        // Unconstrained random traffic, including reads on empty and error clears.
        repeat (400) step(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 5),
                          4'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));

        // Bring occupancy to 100, then pulse Aclr between clock edges.
        iter = 0;
        while (mdl.size() != 100 && iter < 500) begin
            step(mdl.size() < 100, mdl.size() > 100, 4'($urandom), 1'($urandom), 1'b0);
            iter++;
        end
        @(negedge Clock);
        WrReq = 1'b0; RdReq = 1'b0; ErrClr = 1'b0;
        #3;
        Aclr = 1'b1;
        model_reset();
        #1;
        check_reset("aclr");
        @(negedge Clock);
        Aclr = 1'b0;

        // The first word after reset must be the one returned.
        step(1'b1, 1'b0, 4'h9, 1'b1, 1'b0);
        step(1'b0, 1'b1, 4'h0, 1'b0, 1'b0);
        idle();
        idle();

        repeat (3) @(posedge Clock);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lpm_fifo_gen2.md
Name: lpm_fifo_gen2

Overview:
Parametrised successor to the team's 4x256 LPM FIFO: single-clock synchronous FIFO with configurable data width, depth, parity lane and showahead mode. It adds registered almost-empty/almost-full flags, sticky overflow/underflow error flags, and corrected simultaneous read/write handling at the empty and full boundaries. It sits between the EBR-based datapath stages and is the drop-in buffer for new designs.

Parameters:
WIDTH, 4, data bits per word excluding parity
PAR_WIDTH, 1, extra side-band/parity bits stored alongside data (0 allowed)
WIDTHU, 8, address bits; DEPTH = 2**WIDTHU words
SHOWAHEAD, 0, 0 = normal read (Q after RdReq), 1 = first-word-fall-through
AE_LEVEL, 2, AlmostEmpty asserted when UsedW <= AE_LEVEL
AF_LEVEL, 254, AlmostFull asserted when UsedW >= AF_LEVEL

Ports:
Clock  in  1  rising-edge clock
Aclr  in  1  asynchronous active-high reset
Data  in  WIDTH  write data
EDI  in  PAR_WIDTH  side-band write bits
WrReq  in  1  write request
RdReq  in  1  read request
ErrClr  in  1  synchronous clear of Overflow/Underflow
Q  out  WIDTH  read data
EDO  out  PAR_WIDTH  side-band read bits
UsedW  out  WIDTHU+1  word count, 0..DEPTH
Empty, Full  out  1  status
AlmostEmpty, AlmostFull  out  1  threshold status
Overflow, Underflow  out  1  sticky error flags

Behaviour:
- Reset: Aclr (asynchronous, active-high) clears pointers and UsedW to 0; Empty=1, Full=0, AlmostEmpty=1, AlmostFull=0, Overflow=0, Underflow=0, Q/EDO=0. RAM contents are not cleared.
- Aclr mid-operation aborts all pending transfers. The first accepted write after release lands at address 0.
- Accept rules, evaluated on flags at the clock edge:
  - wr_ok = WrReq & ~Full.
  - rd_ok = RdReq & ~Empty.
  - A write when Full is dropped, even if RdReq=1.
  - A read when Empty is dropped, even if WrReq=1; the write is still accepted.
- Count: UsedW_next = UsedW + wr_ok - rd_ok. Both accepted leaves UsedW unchanged.
- Pointers: WIDTHU bits each, wrap naturally from DEPTH-1 to 0.
- Flags: registered and derived from UsedW_next, so they are valid the same cycle as UsedW.
  - Empty = (UsedW==0).
  - Full = (UsedW==DEPTH).
  - AlmostEmpty = (UsedW<=AE_LEVEL).
  - AlmostFull = (UsedW>=AF_LEVEL).
- SHOWAHEAD=0:
  - {EDO,Q} loads RAM[rd_ptr] on the edge where rd_ok=1; latency 1 clock.
  - Q holds its value otherwise, including after the FIFO goes empty.
- SHOWAHEAD=1:
  - {EDO,Q} always presents the head word.
  - A write into an empty FIFO appears on Q one clock after the write edge.
  - After rd_ok, Q shows the next word one clock later.
  - When empty, Q holds the last head value.
- Simultaneous read and write with UsedW==1 under SHOWAHEAD=1: Q shows the new word after the edge, Empty stays 0.
- Errors:
  - Overflow sets on WrReq & Full.
  - Underflow sets on RdReq & Empty.
  - Both are sticky until ErrClr=1 (synchronous) or Aclr.
  - If set and clear occur in the same cycle, set wins.
- Parameter constraints:
  - 0 <= AE_LEVEL < AF_LEVEL <= DEPTH, checked by an elaboration-time assertion.
  - PAR_WIDTH=0 removes the EDI/EDO storage.

Decomposition:
- Package fifo_gen2_pkg holds:
  - DEPTH derivation function (2**WIDTHU).
  - Count-width constant (WIDTHU+1).
  - Default AE/AF threshold functions.
- Sub-module fifo_gen2_dpram: simple dual-port RAM, DEPTH x (WIDTH+PAR_WIDTH).
  - Synchronous write, synchronous read with read-enable; maps to EBR.
- Control, counters, flags and the showahead output register live in lpm_fifo_gen2.

Test Plan:
- Reset, then 3 writes (0x1,0x2,0x3), then 3 reads, SHOWAHEAD=0 -> Q=0x1,0x2,0x3 one clock after each read; UsedW 3->0; Empty=1 after the third read.
- Fill 256 words -> Full=1 and UsedW=256 after write 256. AlmostFull=1 from UsedW=254. A 257th write sets Overflow=1 and UsedW stays 256.
- Read on empty with WrReq=1, data 0xA -> Underflow=1 and UsedW=1. ErrClr pulse -> Underflow=0.
- SHOWAHEAD=1: write 0x5 into empty -> Q=0x5 next cycle with Empty=0. Simultaneous read+write 0x6 -> Q=0x6 and UsedW stays 1.
- Wrap: 300 writes interleaved with reads keeping UsedW in 1..4 -> read data equals write order across pointer wrap, no flag glitches.
- Aclr pulse asynchronous to Clock with UsedW=100 -> UsedW=0, Empty=1, AlmostEmpty=1, Full=0 immediately. The next write/read returns the newly written word.
